// File: rtl/prewish5k_input_conditioner.sv
// Button/DIP input conditioner: 2-flop sync, debounce, press/release/long-press events, DIP snapshot.
// Optional macro PREWISH_DIP_DEBOUNCE_EN adds a whole-vector DIP debouncer ahead of the snapshot.
module prewish5k_input_conditioner #(
  parameter int DEBOUNCE_BITS   = 16,
  parameter int LONG_PRESS_BITS = 26
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_button_n,
  input  logic [7:0] i_dip_n,
  output logic       o_button,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long_press,
  output logic [7:0] o_dip,
  output logic       o_dip_strobe
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  localparam logic [DEBOUNCE_BITS-1:0]   DB_MAX   = '1;
  localparam logic [LONG_PRESS_BITS-1:0] HOLD_MAX = '1;

  logic       btn_meta_q, btn_sync_q;
  logic [7:0] dip_meta_q, dip_sync_q;
  logic       btn_level;
  logic [7:0] dip_level;
  logic [7:0] dip_snap;

  // NOTE: synchronizer flops reset to the raw idle level (1), not 0, so the
  // first cycles after reset never look like a pressed button.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      dip_meta_q <= 8'hFF;
      dip_sync_q <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old value
      // on the same edge; blocking here would collapse the chain to one flop.
      btn_meta_q <= i_button_n;
      btn_sync_q <= btn_meta_q;
      dip_meta_q <= i_dip_n;
      dip_sync_q <= dip_meta_q;
    end
  end

  assign btn_level = ~btn_sync_q;
  assign dip_level = ~dip_sync_q;

  // Button debounce: the stable level flips only after a full-length mismatch.
  logic                     stable_q, stable_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
  logic                     btn_flip, btn_rise, btn_fall;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    stable_d = stable_q;
    db_cnt_d = '0;
    btn_flip = 1'b0;
    if (btn_level != stable_q) begin
      if (db_cnt_q == DB_MAX) begin
        btn_flip = 1'b1;
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign btn_rise = btn_flip & ~stable_q;
  assign btn_fall = btn_flip &  stable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

`ifdef PREWISH_DIP_DEBOUNCE_EN
  // Whole-vector DIP debounce: any bit change restarts the stability count.
  logic [7:0]               dip_last_q, dip_deb_q;
  logic [DEBOUNCE_BITS-1:0] dip_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dip_last_q <= 8'h00;
      dip_deb_q  <= 8'h00;
      dip_cnt_q  <= '0;
    end else begin
      dip_last_q <= dip_level;
      if (dip_level != dip_last_q) begin
        dip_cnt_q <= '0;
      end else if (dip_cnt_q == DB_MAX) begin
        dip_deb_q <= dip_last_q;
      end else begin
        dip_cnt_q <= dip_cnt_q + 1'b1;
      end
    end
  end

  assign dip_snap = dip_deb_q;
`else
  assign dip_snap = dip_level;
`endif

  // Press FSM; event outputs are registered on the same edge the debounced level flips.
  state_e                     state_q, state_d;
  logic [LONG_PRESS_BITS-1:0] hold_q, hold_d;
  logic                       press_q, press_d;
  logic                       release_q, release_d;
  logic                       long_q, long_d;
  logic [7:0]                 dip_q, dip_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    dip_d     = dip_q;
    unique case (state_q)
      IDLE: begin
        if (btn_rise) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
          dip_d   = dip_snap;
        end
      end
      PRESSED: begin
        // Release takes priority over a long press that saturates in the same cycle.
        if (btn_fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (btn_fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      dip_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      dip_q     <= dip_d;
    end
  end

  assign o_button     = stable_q;
  assign o_press      = press_q;
  assign o_release    = release_q;
  assign o_long_press = long_q;
  assign o_dip        = dip_q;
  assign o_dip_strobe = press_q;

endmodule

// File: tb/tb_prewish5k_input_conditioner.sv
// Directed bench for prewish5k_input_conditioner with DEBOUNCE_BITS=4, LONG_PRESS_BITS=6.
module tb_prewish5k_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button_n;
  logic [7:0] dip_n;
  logic       o_button, o_press, o_release, o_long_press, o_dip_strobe;
  logic [7:0] o_dip;

  int checks = 0;
  int errors = 0;

  prewish5k_input_conditioner #(
    .DEBOUNCE_BITS  (4),
    .LONG_PRESS_BITS(6)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_button_n  (button_n),
    .i_dip_n     (dip_n),
    .o_button    (o_button),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_long_press(o_long_press),
    .o_dip       (o_dip),
    .o_dip_strobe(o_dip_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic seen;
  logic [7:0] dip_at_press;

  initial begin
    rst_n    = 1'b0;
    button_n = 1'b1;
    dip_n    = 8'hFF;
    #12;
    check("rst_button",  32'(o_button), 0);
    check("rst_press",   32'(o_press), 0);
    check("rst_release", 32'(o_release), 0);
    check("rst_long",    32'(o_long_press), 0);
    check("rst_dip",     32'(o_dip), 0);
    check("rst_strobe",  32'(o_dip_strobe), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_after_reset", 32'({o_button, o_press}), 0);

    // Glitch reject: 10-cycle low pulse is shorter than the 16-cycle debounce.
    seen = 1'b0;
    button_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) button_n = 1'b1;
      tick();
      if (o_button || o_press || o_release) seen = 1'b1;
    end
    check("glitch_reject", 32'(seen), 0);

    // Clean press with DIP snapshot.
    dip_n = 8'hA5;
    repeat (5) tick();
    button_n = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (o_button || o_press) seen = 1'b1;
    end
    check("press_not_early", 32'(seen), 0);
    tick();
    check("press_button_e18", 32'(o_button), 1);
    check("press_pulse_e18",  32'(o_press), 1);
    check("press_strobe_e18", 32'(o_dip_strobe), 1);
    check("press_dip_e18",    32'(o_dip), 32'h5A);
    dip_n = 8'h00;
    tick();
    check("press_pulse_e19",  32'(o_press), 0);
    check("press_strobe_e19", 32'(o_dip_strobe), 0);
    check("button_held_e19",  32'(o_button), 1);

    // Long press: pulse 64 cycles after the press edge.
    seen = 1'b0;
    for (int i = 2; i <= 63; i++) begin
      tick();
      if (o_long_press || o_dip_strobe) seen = 1'b1;
    end
    check("long_not_early", 32'(seen), 0);
    check("dip_held", 32'(o_dip), 32'h5A);
    tick();
    check("long_pulse_e64", 32'(o_long_press), 1);
    tick();
    check("long_pulse_e65", 32'(o_long_press), 0);
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (o_long_press) seen = 1'b1;
    end
    check("long_once", 32'(seen), 0);
    check("dip_still_held", 32'(o_dip), 32'h5A);

    // Release: same debounce latency as press.
    button_n = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (o_release || !o_button || o_long_press) seen = 1'b1;
    end
    check("release_not_early", 32'(seen), 0);
    tick();
    check("release_pulse_e18", 32'(o_release), 1);
    check("release_button_e18", 32'(o_button), 0);
    tick();
    check("release_pulse_e19", 32'(o_release), 0);
    repeat (5) tick();

    // Reset mid-press while in LONG_HELD.
    button_n = 1'b0;
    repeat (18) tick();
    check("mid_press_pulse", 32'(o_press), 1);
    repeat (64) tick();
    check("mid_long_pulse", 32'(o_long_press), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          32'({o_button, o_press, o_release, o_long_press, o_dip_strobe}), 0);
    check("async_rst_dip", 32'(o_dip), 0);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (o_press || o_button) seen = 1'b1;
    end
    check("post_rst_not_early", 32'(seen), 0);
    tick();
    check("post_rst_press", 32'(o_press), 1);
    button_n = 1'b1;
    repeat (25) tick();
    check("post_rst_released", 32'(o_button), 0);

`ifdef PREWISH_DIP_DEBOUNCE_EN
    // Bouncing DIP never settles, so the snapshot keeps the reset value.
    rst_n = 1'b0;
    button_n = 1'b1;
    dip_n = 8'hFF;
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    dip_at_press = 8'hEE;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) dip_n[0] = ~dip_n[0];
      if (i == 4) button_n = 1'b0;
      tick();
      if (o_press) begin
        seen = 1'b1;
        dip_at_press = o_dip;
      end
    end
    check("macro_bounce_pressed", 32'(seen), 1);
    check("macro_bounce_dip", 32'(dip_at_press), 0);
    dip_n = 8'h3C;
    button_n = 1'b1;
    repeat (40) tick();
    button_n = 1'b0;
    repeat (18) tick();
    check("macro_stable_press", 32'(o_press), 1);
    check("macro_stable_dip", 32'(o_dip), 32'hC3);
    button_n = 1'b1;
    repeat (25) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prewish5k_input_conditioner.md
# prewish5k_input_conditioner

Input-side conditioner for the Upduino board: takes the raw active-low button and 8-bit DIP switch from the pull-up `SB_IO` pads. It synchronizes and debounces them. It emits clean active-high levels, one-cycle press, release and long-press events, and a DIP snapshot latched on each press. It sits between the pad primitives and the controller and replaces the bare inversion now done at the top level.

## Interface
- `DEBOUNCE_BITS`, 16: debounce counter width; a change must persist 2^DEBOUNCE_BITS cycles (≈1.37 ms at 48 MHz).
- `LONG_PRESS_BITS`, 26: hold counter width; a long press is 2^LONG_PRESS_BITS cycles after the press (≈1.4 s at 48 MHz).
- `i_clk`  in  1  single system clock (48 MHz HFOSC).
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_button_n`  in  1  raw button, active low, asynchronous to `i_clk`.
- `i_dip_n`  in  8  raw DIP bits, active low, asynchronous.
- `o_button`  out  1  debounced button level, active high.
- `o_press`  out  1  one-cycle pulse on debounced press.
- `o_release`  out  1  one-cycle pulse on debounced release.
- `o_long_press`  out  1  one-cycle pulse, at most once per press.
- `o_dip`  out  8  active-high DIP snapshot.
- `o_dip_strobe`  out  1  one-cycle pulse when `o_dip` updates; coincident with `o_press`.

## Operation
- **Reset**
  - `i_rst_n` low clears all outputs and counters to 0 and the FSM to IDLE, asynchronously.
  - Synchronizer flops reset to 1 (raw idle level), so reset release never creates a false press.
- **Synchronizer:** two-flop synchronizer on the button and on each DIP bit. Inversion to active high happens after synchronization.
- **Button debounce**
  - Holds a stable level S and a counter C.
  - If the synchronized level equals S, C clears to 0.
  - Otherwise C increments.
  - When C = 2^DEBOUNCE_BITS−1 and the mismatch persists, S flips and C clears on that edge.
  - Any glitch shorter than 2^DEBOUNCE_BITS cycles leaves S unchanged.
  - `o_button` = S.
- **FSM: IDLE, PRESSED, LONG_HELD**
  - IDLE→PRESSED on S rising: `o_press` pulses and hold counter H clears.
  - PRESSED: H increments each cycle. When H = 2^LONG_PRESS_BITS−1, `o_long_press` pulses and the FSM moves to LONG_HELD.
  - PRESSED or LONG_HELD→IDLE on S falling: `o_release` pulses.
  - If S falls in the same cycle that H saturates, release wins: no `o_long_press`.
  - H saturates and never wraps.
- **DIP snapshot**
  - On the edge that asserts `o_press`, `o_dip` loads the current DIP value and `o_dip_strobe` pulses.
  - `o_dip` holds until the next press.

## Timing
- **Button press latency:** raw `i_button_n` is low at edge 1 and held. The synchronized level is low after edge 2. `o_button` and `o_press` go high after edge 2^DEBOUNCE_BITS+2.
- **Release:** same latency for the release path.
- **Pulse widths:** all pulses are registered and exactly 1 cycle wide.
- **Long press:** `o_long_press` asserts 2^LONG_PRESS_BITS cycles after the `o_press` edge.
- **DIP sampling point:** `o_dip` reflects the DIP value synchronized 2 edges before the press edge, or the debounced value under the macro below.
- **Reset mid-press:** outputs drop immediately. A button still held after reset requires a full debounce, then yields a fresh `o_press`.

## Configuration
- Macro: `PREWISH_DIP_DEBOUNCE_EN`.
- **Defined:**
  - An extra DIP-vector debouncer with its own DEBOUNCE_BITS counter is compiled in.
  - The debounced vector updates only after all 8 synchronized bits stay unchanged for 2^DEBOUNCE_BITS consecutive cycles; any bit change restarts the count.
  - The snapshot takes the debounced vector; its reset value is 0.
- **Undefined:** the snapshot takes the 2-flop synchronized vector directly; no extra counter exists.

## Test plan
All scenarios use DEBOUNCE_BITS=4 and LONG_PRESS_BITS=6.
- **Clean press:** drive `i_button_n` low at edge 1 and hold.
  - `o_button` and `o_press` go high after edge 18.
  - `o_press` is low again after edge 19.
- **Glitch reject:** pulse `i_button_n` low for 10 cycles → `o_button`, `o_press` and `o_release` stay 0 throughout.
- **Long press then release:**
  - Hold the button low → `o_long_press` is a single pulse 64 cycles after `o_press`.
  - Release → `o_release` pulses once; no second long press.
- **DIP snapshot:**
  - Set `i_dip_n`=8'hA5 and press → `o_dip`=8'h5A with `o_dip_strobe` at the `o_press` edge.
  - Change `i_dip_n` to 8'h00 while held → `o_dip` stays 8'h5A.
- **Reset mid-press:**
  - Assert `i_rst_n` low during LONG_HELD → all outputs are 0 asynchronously.
  - Release reset with the button still held → `o_press` pulses 2+16 cycles later.
- **Macro defined:** toggle DIP bit 0 every 8 cycles, then press → `o_dip` = 8'h00 (reset value). After the DIP is stable ≥16 cycles, the next press captures the new value.
